// File: rtl/fifo_pkg.sv
// Shared constants for the programmable-threshold synchronous FIFO:
// read-mode selectors and the count/pointer width helper.
package fifo_pkg;

    localparam int FWFT_OFF = 0;  // registered read, one-cycle latency
    localparam int FWFT_ON  = 1;  // head entry visible combinationally

    // Pointer/count width: address bits plus one wrap bit.
    function automatic int cw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// One wrap-bit FIFO pointer: increments modulo 2^CW, synchronous clear
// has priority over increment, asynchronous active-low reset.
module fifo_ptr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rest,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] ptr
);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable FWFT or registered read.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,              // power of two, 2..256
    parameter int WIDTH = 32,
    parameter int FWFT  = FWFT_ON,
    parameter int CW    = cw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             flush,
    input  logic             write,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    output logic             full,
    output logic             empty,
    input  logic [CW-1:0]    af_level,
    input  logic [CW-1:0]    ae_level,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count_w;
    logic             push_ok;
    logic             pop_ok;

    // Handshake: a push is taken on any edge where write is high and there is
    // room, or the FIFO is full but a pop is taken on the same edge; a pop is
    // taken on any edge where read is high and the FIFO is non-empty. There is
    // no backpressure signal beyond full/empty: refused requests only raise
    // the sticky overflow/underflow flags. flush overrides both.
    assign count_w      = wr_ptr - rd_ptr;
    assign count        = count_w;
    assign full         = (count_w == CW'(DEPTH));
    assign empty        = (count_w == '0);
    assign almost_full  = (count_w >= af_level);
    assign almost_empty = (count_w <= ae_level);

    assign pop_ok  = read && !empty;
    assign push_ok = write && (!full || pop_ok);

    fifo_ptr #(.CW(CW)) u_wr_ptr (
        .clk  (clk),
        .rest (rest),
        .clear(flush),
        .inc  (push_ok),
        .ptr  (wr_ptr)
    );

    fifo_ptr #(.CW(CW)) u_rd_ptr (
        .clk  (clk),
        .rest (rest),
        .clear(flush),
        .inc  (pop_ok),
        .ptr  (rd_ptr)
    );

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full && !pop_ok) overflow  <= 1'b1;
            if (read && empty)            underflow <= 1'b1;
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        // Gated while empty so read_data reads as zero out of reset.
        assign read_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
        assign read_valid = !empty;
    end else begin : g_reg
        logic [WIDTH-1:0] rd_q;
        logic             rv_q;

        always_ff @(posedge clk or negedge rest) begin
            if (!rest) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else if (flush) begin
                rv_q <= 1'b0;
            end else begin
                rv_q <= pop_ok;
                if (pop_ok) rd_q <= mem[rd_ptr[AW-1:0]];
            end
        end

        assign read_data  = rd_q;
        assign read_valid = rv_q;
    end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog (DEPTH=8, WIDTH=16): FWFT and registered-read
// instances share stimulus and are checked against a queue-based model.
module tb_fifo_sync_prog;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rest;
    logic             flush;
    logic             write;
    logic [WIDTH-1:0] write_data;
    logic             read;
    logic [CW-1:0]    af_level;
    logic [CW-1:0]    ae_level;

    logic [WIDTH-1:0] f_read_data, r_read_data;
    logic             f_read_valid, r_read_valid;
    logic             f_full, f_empty, r_full, r_empty;
    logic             f_af, f_ae, r_af, r_ae;
    logic [CW-1:0]    f_count, r_count;
    logic             f_ovf, f_unf, r_ovf, r_unf;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fifo_sync_prog #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) u_fwft (
        .clk(clk), .rest(rest), .flush(flush), .write(write),
        .write_data(write_data), .read(read), .read_data(f_read_data),
        .read_valid(f_read_valid), .full(f_full), .empty(f_empty),
        .af_level(af_level), .ae_level(ae_level), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_sync_prog #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) u_reg (
        .clk(clk), .rest(rest), .flush(flush), .write(write),
        .write_data(write_data), .read(read), .read_data(r_read_data),
        .read_valid(r_read_valid), .full(r_full), .empty(r_empty),
        .af_level(af_level), .ae_level(ae_level), .almost_full(r_af),
        .almost_empty(r_ae), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf, m_unf, m_rv;
    logic [WIDTH-1:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = '0;
    endtask

    // Applies one clock edge's worth of FIFO rules to the queue model.
    task automatic model_edge();
        bit is_full, is_empty, pop, push;
        is_full  = (exp_q.size() == DEPTH);
        is_empty = (exp_q.size() == 0);
        if (flush) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            pop  = read && !is_empty;
            push = write && (!is_full || pop);
            if (write && is_full && !pop) m_ovf = 1'b1;
            if (read && is_empty)         m_unf = 1'b1;
            m_rv = pop;
            if (pop)  m_rd = exp_q.pop_front();
            if (push) exp_q.push_back(write_data);
        end
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        chk("count",        32'(f_count), 32'(n));
        chk("reg_count",    32'(r_count), 32'(n));
        chk("full",         32'(f_full),  32'(n == DEPTH));
        chk("empty",        32'(f_empty), 32'(n == 0));
        chk("reg_full",     32'(r_full),  32'(n == DEPTH));
        chk("reg_empty",    32'(r_empty), 32'(n == 0));
        chk("almost_full",  32'(f_af),    32'(n >= int'(af_level)));
        chk("almost_empty", 32'(f_ae),    32'(n <= int'(ae_level)));
        chk("reg_af",       32'(r_af),    32'(n >= int'(af_level)));
        chk("reg_ae",       32'(r_ae),    32'(n <= int'(ae_level)));
        chk("overflow",     32'(f_ovf),   32'(m_ovf));
        chk("underflow",    32'(f_unf),   32'(m_unf));
        chk("reg_overflow", 32'(r_ovf),   32'(m_ovf));
        chk("reg_underflow",32'(r_unf),   32'(m_unf));
        chk("fwft_valid",   32'(f_read_valid), 32'(n != 0));
        chk("fwft_data",    32'(f_read_data),  32'((n != 0) ? exp_q[0] : 16'h0));
        chk("reg_valid",    32'(r_read_valid), 32'(m_rv));
        chk("reg_data",     32'(r_read_data),  32'(m_rd));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] wd, input logic r, input logic fl);
        write      = w;
        write_data = wd;
        read       = r;
        flush      = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        check_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             w;
        logic [WIDTH-1:0] wd;
        logic             r;
        logic             fl;
        int               cnt;
        logic             full;
        logic             af;
        logic             ovf;
        logic             unf;
        logic [WIDTH-1:0] head;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input logic [WIDTH-1:0] wd, input logic r, input logic fl,
                       input int cnt, input logic fu, input logic af, input logic ovf,
                       input logic unf, input logic [WIDTH-1:0] head);
        vec_t v;
        v.w = w; v.wd = wd; v.r = r; v.fl = fl; v.cnt = cnt; v.full = fu;
        v.af = af; v.ovf = ovf; v.unf = unf; v.head = head;
        vecs.push_back(v);
    endtask

    initial begin
        logic [WIDTH-1:0] after_aa [8];
        after_aa = '{16'h0003, 16'h0004, 16'h0005, 16'h0006,
                     16'h0007, 16'h0008, 16'h00AA, 16'h0000};

        // Fill 1..8 with af_level=6, overflow on the 9th, drain in order.
        for (int i = 1; i <= 8; i++) add(1, 16'(i), 0, 0, i, i == 8, i >= 6, 0, 0, 16'h0001);
        add(1, 16'h0009, 0, 0, 8, 1, 1, 1, 0, 16'h0001);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 8 - k, 0, (8 - k) >= 6, 1, 0, (k < 8) ? 16'(k + 1) : 16'h0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0);
        // Refill, then simultaneous write/read while full.
        for (int i = 1; i <= 8; i++) add(1, 16'(i), 0, 0, i, i == 8, i >= 6, 0, 0, 16'h0001);
        add(1, 16'h00AA, 1, 0, 8, 1, 1, 0, 0, 16'h0002);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 8 - k, 0, (8 - k) >= 6, 0, 0, after_aa[k-1]);
        // Empty read, then flush clears underflow.
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0);

        // ---- reset state ----
        rest = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0;
        write_data = '0; af_level = 4'd6; ae_level = 4'd1;
        model_reset();
        #12;
        check_all();
        chk("rst_empty", 32'(f_empty), 32'd1);
        chk("rst_ae",    32'(f_ae),    32'd1);

        // ---- reset released mid-phase; first push on the first rising edge ----
        @(negedge clk);
        write = 1'b1; write_data = 16'h00C1;
        #3 rest = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        write = 1'b0;
        check_all();
        chk("first_push_cnt", 32'(f_count), 32'd1);
        cycle(0, 0, 1, 0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].w, vecs[i].wd, vecs[i].r, vecs[i].fl);
            chk($sformatf("vec%0d_count", i), 32'(f_count),       32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i),  32'(f_full),        32'(vecs[i].full));
            chk($sformatf("vec%0d_af", i),    32'(f_af),          32'(vecs[i].af));
            chk($sformatf("vec%0d_ovf", i),   32'(f_ovf),         32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i),   32'(f_unf),         32'(vecs[i].unf));
            chk($sformatf("vec%0d_head", i),  32'(f_read_data),   32'(vecs[i].head));
        end

        // ---- registered read latency ----
        cycle(1, 16'h1234, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("reg_lat_valid", 32'(r_read_valid), 32'd1);
        chk("reg_lat_data",  32'(r_read_data),  32'h1234);
        cycle(0, 0, 0, 0);
        chk("reg_hold_valid", 32'(r_read_valid), 32'd0);
        chk("reg_hold_data",  32'(r_read_data),  32'h1234);

        // ---- wrap with occupancy 0..3 ----
        for (int g = 0; g < 7; g++) begin
            int n;
            n = (g == 6) ? 2 : 3;
            for (int j = 0; j < n; j++) begin
                cycle(1, 16'($urandom), 0, 0);
                chk("wrap_cnt_le3", 32'(f_count <= 4'd3), 32'd1);
            end
            for (int j = 0; j < n; j++) cycle(0, 0, 1, 0);
        end
        chk("wrap_no_ovf", 32'(f_ovf), 32'd0);
        chk("wrap_no_unf", 32'(f_unf), 32'd0);

        // ---- randomized traffic with random thresholds ----
        for (int t = 0; t < 300; t++) begin
            af_level = 4'($urandom_range(0, 15));
            ae_level = 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0));
        end

        // ---- asynchronous reset mid-stream at count 5 ----
        af_level = 4'd6; ae_level = 4'd1;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 16'($urandom), 0, 0);
        chk("pre_rst_count", 32'(f_count), 32'd5);
        #2 rest = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("mid_rst_count", 32'(f_count),     32'd0);
        chk("mid_rst_rdata", 32'(r_read_data), 32'd0);
        #1 rest = 1'b1;
        @(negedge clk);
        check_all();
        cycle(1, 16'h55AA, 0, 0);
        chk("post_rst_head", 32'(f_read_data), 32'h55AA);
        cycle(0, 0, 1, 0);
        chk("post_rst_pop",  32'(r_read_data), 32'h55AA);
        chk("post_rst_empty", 32'(f_empty),    32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
